hazard_unit: RTL and testbench
==============================

HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 Parameter DIV_CYCLES, default 4: number of cycles a multi-cycle mul/div op occupies EX; legal range 2..16.
REQ-002 clk  input  1  pipeline clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Rs1D, Rs2D  input  5 each  source register indices of instruction in Decode.
REQ-005 Rs1E, Rs2E  input  5 each  source register indices of instruction in Execute.
REQ-006 RdE, RdM, RdW  input  5 each  destination register indices in Execute, Memory, Writeback.
REQ-007 RegWriteM, RegWriteW  input  1 each  destination write enable in Memory, Writeback.
REQ-008 MemReadE  input  1  instruction in Execute is a load.
REQ-009 PCSrcE  input  1  taken branch/jump resolved in Execute.
REQ-010 MulDivStartE  input  1  instruction in Execute is a multi-cycle mul/div op.
REQ-011 ForwardAE, ForwardBE  output  2 each  operand A/B select: 00 register file, 01 ResultW, 10 ALUResultM.
REQ-012 StallF, StallD, StallE  output  1 each  hold PC, IF/ID, ID/EX registers.
REQ-013 FlushD, FlushE  output  1 each  clear IF/ID, ID/EX registers to bubble.
REQ-014 MulDivDone  output  1  final EX cycle of a multi-cycle op.

Function
REQ-015 ForwardAE SHALL be 10 when RegWriteM=1, RdM!=0, RdM==Rs1E; else 01 when RegWriteW=1, RdW!=0, RdW==Rs1E; else 00 (Memory priority over Writeback).
REQ-016 ForwardBE SHALL follow REQ-015 with Rs2E in place of Rs1E.
REQ-017 Forward outputs SHALL be purely combinational, zero latency, independent of stall/FSM state; code 11 SHALL never be driven.
REQ-018 LoadUse SHALL be MemReadE=1 and RdE!=0 and (RdE==Rs1D or RdE==Rs2D).
REQ-019 LoadUse with PCSrcE=0 SHALL assert StallF, StallD, FlushE for exactly that cycle (one bubble).
REQ-020 PCSrcE=1 SHALL assert FlushD and FlushE and SHALL suppress LoadUse-driven StallF/StallD.
REQ-021 FSM SHALL have two states, IDLE and BUSY, plus a 4-bit down-counter Count.
REQ-022 IDLE with MulDivStartE=1: StallF, StallD, StallE asserted combinationally; next state BUSY, Count loaded with DIV_CYCLES-2.
REQ-023 BUSY with Count!=0: StallF, StallD, StallE asserted; Count decrements by 1; stays BUSY.
REQ-024 BUSY with Count==0: stalls deasserted, MulDivDone=1, MulDivStartE ignored; next state IDLE.
REQ-025 Result: op occupies EX exactly DIV_CYCLES cycles with DIV_CYCLES-1 stall cycles; back-to-back mul/div ops restart from IDLE on the cycle after MulDivDone.
REQ-026 While StallE=1, FlushE SHALL be forced to 0 (no kill of the op in EX); FlushD still follows PCSrcE.
REQ-027 StallF and StallD SHALL be the OR of LoadUse stall (REQ-019/020) and mul/div stall (REQ-022/023).
REQ-028 IDLE with MulDivStartE=0: no FSM stalls, MulDivDone=0, Count held at 0.

Reset
REQ-029 rst_n low SHALL immediately force state IDLE and Count 0, independent of clk, including mid-BUSY.
REQ-030 During reset, MulDivDone=0 and FSM stalls=0; forward, LoadUse and flush outputs remain combinational functions of inputs.
REQ-031 First rising edge after rst_n rises SHALL evaluate from IDLE.

Verification
REQ-032 RdM=5, RegWriteM=1, RdW=5, RegWriteW=1, Rs1E=5, Rs2E=5 -> ForwardAE=10, ForwardBE=10; with RdM=0 instead -> both 01; RdW=0 too -> both 00.
REQ-033 MemReadE=1, RdE=7, Rs2D=7, PCSrcE=0 -> StallF=StallD=FlushE=1 for one cycle; same with RdE=0 -> all 0.
REQ-034 DIV_CYCLES=4, MulDivStartE held high 4 cycles -> StallE=1 in cycles 0-2, MulDivDone=1 and StallE=0 in cycle 3, FSM IDLE in cycle 4.
REQ-035 Two consecutive mul/div ops (start high 8 cycles, DIV_CYCLES=4) -> MulDivDone pulses in cycles 3 and 7, StallE low only in cycles 3 and 7.
REQ-036 rst_n pulled low in cycle 1 of a BUSY sequence (between edges) -> StallF/D/E drop immediately; after release with MulDivStartE=0, state IDLE, no stall.
REQ-037 PCSrcE=1 with MemReadE=1, RdE=Rs1D=3 -> FlushD=FlushE=1, StallF=StallD=0.

Source files
------------

// File: rtl/hazard_unit.sv
// -----------------------------------------------------------------------------
// hazard_unit
//
// Hazard detection and resolution for a 5-stage in-order pipeline with a
// multi-cycle mul/div unit in Execute.
//
// The unit does three jobs:
//   * Operand forwarding into Execute from Memory or Writeback.
//   * Load-use stalls, and flushes on a taken branch or jump.
//   * A two-state FSM that holds the front of the pipe while a mul/div op
//     occupies EX for DIV_CYCLES cycles.
//
// Parameters
//   DIV_CYCLES    cycles a mul/div op spends in EX (2..16)
//
// Ports
//   clk           pipeline clock, rising edge
//   rst_n         asynchronous active-low reset
//   Rs1D, Rs2D    source registers of the instruction in Decode
//   Rs1E, Rs2E    source registers of the instruction in Execute
//   RdE/RdM/RdW   destination registers in Execute/Memory/Writeback
//   RegWriteM/W   destination write enables in Memory/Writeback
//   MemReadE      instruction in Execute is a load
//   PCSrcE        taken branch/jump resolved in Execute
//   MulDivStartE  instruction in Execute is a multi-cycle mul/div op
//   ForwardAE/BE  operand select: 00 regfile, 01 ResultW, 10 ALUResultM
//   StallF/D/E    hold PC, IF/ID, ID/EX
//   FlushD/E      clear IF/ID, ID/EX to a bubble
//   MulDivDone    final EX cycle of a multi-cycle op
// -----------------------------------------------------------------------------
module hazard_unit #(
    parameter int DIV_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] Rs1D,
    input  logic [4:0] Rs2D,
    input  logic [4:0] Rs1E,
    input  logic [4:0] Rs2E,
    input  logic [4:0] RdE,
    input  logic [4:0] RdM,
    input  logic [4:0] RdW,
    input  logic       RegWriteM,
    input  logic       RegWriteW,
    input  logic       MemReadE,
    input  logic       PCSrcE,
    input  logic       MulDivStartE,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE,
    output logic       StallF,
    output logic       StallD,
    output logic       StallE,
    output logic       FlushD,
    output logic       FlushE,
    output logic       MulDivDone
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // The first EX cycle is spent in IDLE, and the last is the Count==0
    // cycle in BUSY. That leaves DIV_CYCLES-2 decrements in between.
    localparam logic [3:0] COUNT_LOAD = 4'(DIV_CYCLES - 2);

    state_t     state;
    state_t     state_next;
    logic [3:0] count;
    logic [3:0] count_next;
    logic       md_stall;
    logic       load_use;
    logic       lu_stall;

    // Forwarding: Memory holds the younger result, so it takes priority.
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
        if (RegWriteM && (RdM != 5'd0) && (RdM == rs)) begin
            return FWD_MEM;
        end else if (RegWriteW && (RdW != 5'd0) && (RdW == rs)) begin
            return FWD_WB;
        end else begin
            return FWD_RF;
        end
    endfunction

    assign ForwardAE = fwd_sel(Rs1E);
    assign ForwardBE = fwd_sel(Rs2E);

    assign load_use = MemReadE && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));
    // When a branch is taken, the Decode instruction is killed, so there is
    // nothing left to protect.
    assign lu_stall = load_use && !PCSrcE;

    // NOTE: sequential state uses non-blocking assignments. Every reader then
    // sees the pre-edge value, whatever the order of the processes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            count <= 4'd0;
        end else begin
            state <= state_next;
            count <= count_next;
        end
    end

    // NOTE: every output of this block gets a default first. Without that, a
    // branch that leaves one unassigned would infer a latch.
    always_comb begin
        state_next = state;
        count_next = 4'd0;
        md_stall   = 1'b0;
        MulDivDone = 1'b0;
        unique case (state)
            IDLE: begin
                if (MulDivStartE) begin
                    md_stall   = 1'b1;
                    state_next = BUSY;
                    count_next = COUNT_LOAD;
                end
            end
            BUSY: begin
                if (count != 4'd0) begin
                    md_stall   = 1'b1;
                    count_next = count - 4'd1;
                end else begin
                    // Final EX cycle. A start seen here belongs to this op,
                    // so it is ignored. A back-to-back op starts from IDLE
                    // on the next cycle.
                    MulDivDone = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        // The state is already IDLE during reset, but a start input must not
        // raise a stall while the pipeline is being reset.
        if (!rst_n) begin
            md_stall = 1'b0;
        end
    end

    assign StallF = lu_stall || md_stall;
    assign StallD = lu_stall || md_stall;
    assign StallE = md_stall;

    assign FlushD = PCSrcE;
    // A held ID/EX register contains the live mul/div op, so it is never
    // bubbled.
    assign FlushE = (lu_stall || PCSrcE) && !md_stall;

endmodule

// File: tb/tb_hazard_unit.sv
module tb_hazard_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic       RegWriteM, RegWriteW, MemReadE, PCSrcE, MulDivStartE;
    logic [1:0] ForwardAE, ForwardBE;
    logic       StallF, StallD, StallE, FlushD, FlushE, MulDivDone;
    // Second instance with the minimum op length; it shares the inputs.
    logic [1:0] fa2, fb2;
    logic       sf2, sd2, se2, fd2, fe2, done2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_unit #(.DIV_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemReadE(MemReadE), .PCSrcE(PCSrcE), .MulDivStartE(MulDivStartE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE),
        .FlushD(FlushD), .FlushE(FlushE), .MulDivDone(MulDivDone)
    );

    hazard_unit #(.DIV_CYCLES(2)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemReadE(MemReadE), .PCSrcE(PCSrcE), .MulDivStartE(MulDivStartE),
        .ForwardAE(fa2), .ForwardBE(fb2),
        .StallF(sf2), .StallD(sd2), .StallE(se2),
        .FlushD(fd2), .FlushE(fe2), .MulDivDone(done2)
    );

    typedef struct {
        logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
        logic       rwm, rww, memrd, pcsrc;
        logic [1:0] fa, fb;
        logic       sf, sd, se, fd, fe;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
        RegWriteM = 0; RegWriteW = 0; MemReadE = 0; PCSrcE = 0; MulDivStartE = 0;
    endtask

    // Runs a mul/div op with the start input held high for n cycles, and
    // checks StallE and MulDivDone each cycle against op boundaries every
    // 4 cycles (dut) and every 2 cycles (dut2).
    task automatic run_ops(input string tag, input int n);
        MulDivStartE = 1'b1;
        for (int i = 0; i < n; i++) begin
            #1;
            check($sformatf("%s StallE c%0d", tag, i), StallE, (i % 4) != 3);
            check($sformatf("%s StallF c%0d", tag, i), StallF, (i % 4) != 3);
            check($sformatf("%s Done c%0d", tag, i), MulDivDone, (i % 4) == 3);
            check($sformatf("%s Done2 c%0d", tag, i), done2, (i % 2) == 1);
            @(negedge clk);
        end
        MulDivStartE = 1'b0;
        #1;
        check({tag, " idle StallE"}, StallE, 1'b0);
        check({tag, " idle Done"}, MulDivDone, 1'b0);
        @(negedge clk);
    endtask

    initial begin
        //          rs1d rs2d rs1e rs2e rde rdm rdw rwm rww mrd pcs  fa fb sf sd se fd fe
        vecs[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0};
        vecs[1]  = '{0, 0, 5, 5, 0, 5, 5, 1, 1, 0, 0,  2, 2, 0, 0, 0, 0, 0};
        vecs[2]  = '{0, 0, 5, 5, 0, 0, 5, 1, 1, 0, 0,  1, 1, 0, 0, 0, 0, 0};
        vecs[3]  = '{0, 0, 5, 5, 0, 0, 0, 1, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0};
        vecs[4]  = '{0, 0, 5, 5, 0, 5, 5, 0, 1, 0, 0,  1, 1, 0, 0, 0, 0, 0};
        vecs[5]  = '{0, 0, 3, 4, 0, 3, 4, 1, 1, 0, 0,  2, 1, 0, 0, 0, 0, 0};
        vecs[6]  = '{0, 0, 6, 5, 0, 5, 9, 1, 1, 0, 0,  0, 2, 0, 0, 0, 0, 0};
        vecs[7]  = '{1, 7, 0, 0, 7, 0, 0, 0, 0, 1, 0,  0, 0, 1, 1, 0, 0, 1};
        vecs[8]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0, 0, 0};
        vecs[9]  = '{1, 7, 0, 0, 7, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0};
        vecs[10] = '{3, 0, 0, 0, 3, 0, 0, 0, 0, 1, 1,  0, 0, 0, 0, 0, 1, 1};
        vecs[11] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 1, 1};
        vecs[12] = '{7, 2, 0, 0, 7, 0, 0, 0, 0, 1, 0,  0, 0, 1, 1, 0, 0, 1};

        // During reset: the FSM stalls are held off, and forwarding stays live.
        clear_inputs();
        rst_n = 1'b0;
        MulDivStartE = 1'b1;
        RdM = 5; RegWriteM = 1; Rs1E = 5;
        #1;
        check("reset StallE", StallE, 1'b0);
        check("reset StallF", StallF, 1'b0);
        check("reset Done", MulDivDone, 1'b0);
        check("reset ForwardAE", ForwardAE, 2'b10);
        clear_inputs();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Combinational vectors, applied with the FSM idle.
        for (int i = 0; i < 13; i++) begin
            Rs1D = vecs[i].rs1d; Rs2D = vecs[i].rs2d;
            Rs1E = vecs[i].rs1e; Rs2E = vecs[i].rs2e;
            RdE = vecs[i].rde; RdM = vecs[i].rdm; RdW = vecs[i].rdw;
            RegWriteM = vecs[i].rwm; RegWriteW = vecs[i].rww;
            MemReadE = vecs[i].memrd; PCSrcE = vecs[i].pcsrc;
            #1;
            check($sformatf("v%0d ForwardAE", i), ForwardAE, vecs[i].fa);
            check($sformatf("v%0d ForwardBE", i), ForwardBE, vecs[i].fb);
            check($sformatf("v%0d StallF", i), StallF, vecs[i].sf);
            check($sformatf("v%0d StallD", i), StallD, vecs[i].sd);
            check($sformatf("v%0d StallE", i), StallE, vecs[i].se);
            check($sformatf("v%0d FlushD", i), FlushD, vecs[i].fd);
            check($sformatf("v%0d FlushE", i), FlushE, vecs[i].fe);
            @(negedge clk);
        end
        clear_inputs();
        @(negedge clk);

        // One op, then two back-to-back ops.
        run_ops("single", 4);
        run_ops("b2b", 8);

        // A branch taken while the op holds EX: FlushE is suppressed until the
        // done cycle. A load-use in the same cycle still stalls.
        MulDivStartE = 1'b1;
        #1;
        @(negedge clk);
        PCSrcE = 1'b1;
        #1;
        check("busy pcsrc FlushE", FlushE, 1'b0);
        check("busy pcsrc FlushD", FlushD, 1'b1);
        check("busy pcsrc StallF", StallF, 1'b1);
        PCSrcE = 1'b0;
        MemReadE = 1; RdE = 4; Rs1D = 4;
        #1;
        check("busy loaduse FlushE", FlushE, 1'b0);
        check("busy loaduse StallD", StallD, 1'b1);
        clear_inputs();
        MulDivStartE = 1'b1;
        @(negedge clk);
        @(negedge clk);
        PCSrcE = 1'b1;
        #1;
        check("done pcsrc Done", MulDivDone, 1'b1);
        check("done pcsrc FlushE", FlushE, 1'b1);
        clear_inputs();
        @(negedge clk);
        @(negedge clk);

        // Reset asserted mid-BUSY (cycle 1, between edges).
        MulDivStartE = 1'b1;
        @(negedge clk);
        #1;
        check("pre-reset StallE", StallE, 1'b1);
        rst_n = 1'b0;
        #1;
        check("mid-reset StallE", StallE, 1'b0);
        check("mid-reset StallF", StallF, 1'b0);
        check("mid-reset StallD", StallD, 1'b0);
        @(negedge clk);
        MulDivStartE = 1'b0;
        rst_n = 1'b1;
        #1;
        check("post-reset StallE", StallE, 1'b0);
        check("post-reset Done", MulDivDone, 1'b0);
        @(negedge clk);
        #1;
        check("post-reset c1 StallE", StallE, 1'b0);
        check("post-reset c1 Done", MulDivDone, 1'b0);
        @(negedge clk);

        // A fresh op after reset counts its full length from IDLE.
        run_ops("after reset", 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
